memory_cell_ctrl: RTL and testbench

Address and handshake sequencer placed between the LSTM activation/output stage and the dual-port memory cell array. Port A side: accepts a stream of NUM activation words per timestep and writes them at address t*NUM+idx, advancing the timestep counter with wrap-around. Port B side: independently streams any stored timestep vector back out, with valid/last flags, compensating for the memory's one-cycle registered read.

---
 rtl/memory_cell_ctrl_if.sv | 35 +++
 rtl/memory_cell_ctrl.sv | 166 ++++++++++++++++
 tb/tb_memory_cell_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_cell_ctrl_if.sv
// Handshake/bus bundle between memory_cell_ctrl, the activation stage and the memory array.
// slave = controller view, master = environment view.
interface memory_cell_ctrl_if #(
    parameter int ADDR  = 12,
    parameter int WIDTH = 32
);
    logic             start;
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             i_ready;
    logic             done;
    logic [ADDR-1:0]  t_wr;
    logic             wr_a;
    logic [ADDR-1:0]  addr_a;
    logic [WIDTH-1:0] i_a;
    logic             rd_start;
    logic [ADDR-1:0]  rd_t;
    logic [ADDR-1:0]  addr_b;
    logic [WIDTH-1:0] o_b;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             rd_busy;
    logic             err;

    modport slave (
        input  start, i_valid, i_data, rd_start, rd_t, o_b,
        output i_ready, done, t_wr, wr_a, addr_a, i_a, addr_b, r_valid, r_data, r_last, rd_busy, err
    );

    modport master (
        output start, i_valid, i_data, rd_start, rd_t, o_b,
        input  i_ready, done, t_wr, wr_a, addr_a, i_a, addr_b, r_valid, r_data, r_last, rd_busy, err
    );
endinterface

// File: rtl/memory_cell_ctrl.sv
// Port A timestep-vector writer and port B vector reader for the LSTM memory cell array.
// Optional MEMCTRL_HAZARD_CHECK_EN: reject and flag out-of-range or write-colliding reads.
module memory_cell_ctrl #(
    parameter int ADDR     = 12,
    parameter int WIDTH    = 32,
    parameter int NUM      = 53,
    parameter int TIMESTEP = 1
) (
    input  logic           clk,
    input  logic           rst,
    memory_cell_ctrl_if.slave bus
);
    localparam logic [ADDR-1:0] NUM_A    = ADDR'(NUM);
    localparam logic [ADDR-1:0] LAST_IDX = ADDR'(NUM - 1);
    localparam logic [ADDR-1:0] TS_A     = ADDR'(TIMESTEP);
    localparam logic [ADDR-1:0] TS_LAST  = ADDR'(TIMESTEP - 1);
    localparam logic [ADDR-1:0] ONE      = ADDR'(1);

    typedef enum logic [1:0] {W_IDLE, W_WR, W_DONE} wst_e;
    typedef enum logic       {R_IDLE, R_RD}         rdst_e;

    wst_e            wst_q, wst_d;
    logic [ADDR-1:0] idx_q, idx_d;
    logic [ADDR-1:0] t_wr_q, t_wr_d;
    logic [ADDR-1:0] wr_base_q, wr_base_d;
    logic            accept;

    rdst_e           rdst_q, rdst_d;
    logic [ADDR-1:0] rd_base_q, rd_base_d;
    logic [ADDR-1:0] ridx_q, ridx_d;
    logic            r_vld_q, r_last_q;
    logic            issue, issue_last;
    logic            rd_reject, rd_go;

    assign accept = (wst_q == W_WR) && bus.i_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wst_q     <= W_IDLE;
            idx_q     <= '0;
            t_wr_q    <= '0;
            wr_base_q <= '0;
        end else begin
            wst_q     <= wst_d;
            idx_q     <= idx_d;
            t_wr_q    <= t_wr_d;
            wr_base_q <= wr_base_d;
        end
    end

    always_comb begin
        wst_d     = wst_q;
        idx_d     = idx_q;
        t_wr_d    = t_wr_q;
        wr_base_d = wr_base_q;
        case (wst_q)
            W_IDLE: begin
                if (bus.start) begin
                    wst_d = W_WR;
                    idx_d = '0;
                end
            end
            W_WR: begin
                if (accept) begin
                    // idx returns to 0 on the last word so addr_a stays at a valid base afterwards
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        wst_d = W_DONE;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            W_DONE: begin
                wst_d = W_IDLE;
                if (t_wr_q == TS_LAST) begin
                    t_wr_d    = '0;
                    wr_base_d = '0;
                end else begin
                    t_wr_d    = t_wr_q + ONE;
                    wr_base_d = wr_base_q + NUM_A;
                end
            end
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        bus.i_ready = (wst_q == W_WR);
        bus.done    = (wst_q == W_DONE);
        bus.wr_a    = accept;
        bus.addr_a  = wr_base_q + idx_q;
        bus.i_a     = bus.i_data;
        bus.t_wr    = t_wr_q;
    end

`ifdef MEMCTRL_HAZARD_CHECK_EN
    logic err_q;
    assign rd_reject = (bus.rd_t >= TS_A) || ((bus.rd_t == t_wr_q) && (wst_q == W_WR));

    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= bus.rd_start && (rdst_q == R_IDLE) && rd_reject;
    end
`else
    assign rd_reject = (bus.rd_t >= TS_A);
`endif

    assign rd_go      = bus.rd_start && (rdst_q == R_IDLE) && !rd_reject;
    assign issue      = (rdst_q == R_RD);
    assign issue_last = issue && (ridx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdst_q    <= R_IDLE;
            rd_base_q <= '0;
            ridx_q    <= '0;
            r_vld_q   <= 1'b0;
            r_last_q  <= 1'b0;
        end else begin
            rdst_q    <= rdst_d;
            rd_base_q <= rd_base_d;
            ridx_q    <= ridx_d;
            // memory read is registered, so flags trail the issued address by one cycle
            r_vld_q   <= issue;
            r_last_q  <= issue_last;
        end
    end

    always_comb begin
        rdst_d    = rdst_q;
        rd_base_d = rd_base_q;
        ridx_d    = ridx_q;
        case (rdst_q)
            R_IDLE: begin
                if (rd_go) begin
                    rdst_d    = R_RD;
                    rd_base_d = bus.rd_t * NUM_A;
                    ridx_d    = '0;
                end
            end
            R_RD: begin
                if (ridx_q == LAST_IDX) begin
                    ridx_d = '0;
                    rdst_d = R_IDLE;
                end else begin
                    ridx_d = ridx_q + ONE;
                end
            end
            default: rdst_d = R_IDLE;
        endcase
    end

    always_comb begin
        bus.addr_b  = rd_base_q + ridx_q;
        bus.r_valid = r_vld_q;
        bus.r_last  = r_last_q;
        bus.r_data  = bus.o_b;
        bus.rd_busy = issue || r_last_q;
`ifdef MEMCTRL_HAZARD_CHECK_EN
        bus.err     = err_q;
`else
        bus.err     = 1'b0;
`endif
    end
endmodule

// File: tb/tb_memory_cell_ctrl.sv
// Randomized bench for memory_cell_ctrl: behavioural memory array plus an address-map
// reference model (vector v of timestep t lands at t*NUM..t*NUM+NUM-1).
module tb_memory_cell_ctrl;
    localparam int ADDR  = 12;
    localparam int WIDTH = 32;
    localparam int NUM   = 53;
    localparam int TS    = 3;
    localparam int DEPTH = NUM * TS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_cell_ctrl_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

    memory_cell_ctrl #(.ADDR(ADDR), .WIDTH(WIDTH), .NUM(NUM), .TIMESTEP(TS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // memory array with registered port B read
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.wr_a && (int'(bus.addr_a) < DEPTH)) mem[bus.addr_a] <= bus.i_a;
        if (int'(bus.addr_b) < DEPTH) bus.o_b <= mem[bus.addr_b];
    end

    logic [WIDTH-1:0] ref_mem [DEPTH];
    int m_twr;
    int n_cmp;
    int n_mis;
    bit ab;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_i_ready", 64'(bus.i_ready), 64'(0));
        chk("rst_done",    64'(bus.done),    64'(0));
        chk("rst_wr_a",    64'(bus.wr_a),    64'(0));
        chk("rst_addr_a",  64'(bus.addr_a),  64'(0));
        chk("rst_i_a",     64'(bus.i_a),     64'(bus.i_data));
        chk("rst_t_wr",    64'(bus.t_wr),    64'(0));
        chk("rst_addr_b",  64'(bus.addr_b),  64'(0));
        chk("rst_r_valid", 64'(bus.r_valid), 64'(0));
        chk("rst_r_last",  64'(bus.r_last),  64'(0));
        chk("rst_rd_busy", 64'(bus.rd_busy), 64'(0));
        chk("rst_err",     64'(bus.err),     64'(0));
    endtask

    // pat 0: full rate, data idx+1; 1: valid every other cycle; 2: random valid/data
    task automatic wr_vec(input int pat, input int abort_at, output bit aborted);
        int cnt;
        int cyc;
        int base;
        aborted = 1'b0;
        base = m_twr * NUM;
        cnt = 0;
        cyc = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (cnt < NUM && cyc < 500) begin
            case (pat)
                0:       bus.i_valid = 1'b1;
                1:       bus.i_valid = ((cyc % 2) == 0);
                default: bus.i_valid = 1'($urandom_range(0, 1));
            endcase
            bus.i_data = (pat == 0) ? WIDTH'(cnt + 1) : $urandom;
            @(negedge clk);
            chk("i_ready", 64'(bus.i_ready), 64'(1));
            chk("wr_a",    64'(bus.wr_a),    64'(bus.i_valid));
            chk("addr_a",  64'(bus.addr_a),  64'(base + cnt));
            if (bus.i_valid) begin
                chk("i_a", 64'(bus.i_a), 64'(bus.i_data));
                ref_mem[base + cnt] = bus.i_data;
                cnt++;
            end
            cyc++;
            if (abort_at > 0 && cnt == abort_at) begin
                aborted = 1'b1;
                return;
            end
            if (cnt < NUM) begin
                @(posedge clk); #1;
            end
        end
        chk("wr_count", 64'(cnt), 64'(NUM));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        // a start during DONE must be ignored
        if (pat == 0) bus.start = 1'b1;
        @(negedge clk);
        chk("done",         64'(bus.done),    64'(1));
        chk("i_ready_done", 64'(bus.i_ready), 64'(0));
        chk("wr_a_done",    64'(bus.wr_a),    64'(0));
        m_twr = (m_twr + 1) % TS;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_pulse",   64'(bus.done),    64'(0));
        chk("i_ready_idle", 64'(bus.i_ready), 64'(0));
        chk("t_wr",         64'(bus.t_wr),    64'(m_twr));
    endtask

    // returns at the negedge of the final cycle so a following call is back-to-back
    task automatic rd_vec(input int t);
        bit   go;
        logic exp_err;
        go = (t < TS);
        exp_err = 1'b0;
`ifdef MEMCTRL_HAZARD_CHECK_EN
        exp_err = !go;
`endif
        bus.rd_t = ADDR'(t);
        bus.rd_start = 1'b1;
        for (int c = 1; c <= NUM + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.rd_start = 1'b0;
            @(negedge clk);
            chk("err", 64'(bus.err), (c == 1) ? 64'(exp_err) : 64'(0));
            if (go) begin
                if (c <= NUM) chk("addr_b", 64'(bus.addr_b), 64'(t * NUM + c - 1));
                chk("r_valid", 64'(bus.r_valid), 64'(c >= 2));
                chk("r_last",  64'(bus.r_last),  64'(c == NUM + 1));
                chk("rd_busy", 64'(bus.rd_busy), 64'(1));
                if (c >= 2) chk("r_data", 64'(bus.r_data), 64'(ref_mem[t * NUM + c - 2]));
            end else begin
                chk("r_valid_rej", 64'(bus.r_valid), 64'(0));
                chk("rd_busy_rej", 64'(bus.rd_busy), 64'(0));
            end
        end
    endtask

    task automatic rd_idle_chk();
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_busy_end", 64'(bus.rd_busy), 64'(0));
        chk("r_valid_end", 64'(bus.r_valid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit after %0d compares", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        m_twr = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        bus.rd_start = 1'b0;
        bus.rd_t = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst = 1'b1;

        wr_vec(0, 0, ab);
        wr_vec(1, 0, ab);
        rd_vec(1);
        rd_vec(0);
        rd_vec(5);
        rd_idle_chk();

        // reset mid-vector: partial words stay, t_wr and addressing restart at 0
        wr_vec(2, 20, ab);
        chk("aborted", 64'(ab), 64'(1));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset();
        rst = 1'b1;
        m_twr = 0;

        wr_vec(0, 0, ab);
        wr_vec(2, 0, ab);
        wr_vec(2, 0, ab);
        wr_vec(1, 0, ab);
        rd_vec(2);
        rd_vec(0);
        rd_vec(1);
        rd_idle_chk();
        rd_vec(int'($urandom_range(0, TS - 1)));
        rd_idle_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
